// File: rtl/dual_fetch_queue.sv
// rtl/dual_fetch_queue.sv - instruction fetch queue feeding a dual-issue scheduler
// Single-outstanding imem fetch into a circular FIFO exposing the two oldest words.
module dual_fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        consume0,
  input  logic        consume1,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] instruction0,
  output logic [31:0] instruction1,
  output logic [31:0] pc0,
  output logic [31:0] pc1,
  output logic        nothing_filled
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_DISCARD} state_e;

  state_e             state_q;
  logic [31:0]        fetch_pc_q;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               req_q;
  logic [31:0]        addr_q;
  logic [63:0]        mem_q [DEPTH];

  logic               ack_v;
  logic               push;
  logic [1:0]         pops;
  logic [CNT_W-1:0]   count_d;
  logic               has_room;
  logic [31:0]        pc_inc;
  logic [PTR_W-1:0]   head_nx;
  logic [63:0]        entry0;
  logic [63:0]        entry1;

  always_comb begin
    ack_v = req_q & imem_ack;
    push  = ack_v && (state_q == S_FETCH) && !flush;
    pops  = 2'd0;
    if (!flush && consume0 && (count_q != '0)) begin
      pops = 2'd1;
      if (consume1 && (count_q >= CNT_W'(2)))
        pops = 2'd2;
    end
    count_d  = count_q + CNT_W'(push) - CNT_W'(pops);
    has_room = count_d < CNT_W'(DEPTH);
    pc_inc   = fetch_pc_q + 32'd4;
    head_nx  = head_q + PTR_W'(1);
  end

  // A flush with an un-acked request in flight must wait out that request in DISCARD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else if (flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= flush_pc;
      req_q      <= 1'b1;
      if (req_q && !imem_ack) begin
        state_q <= S_DISCARD;
      end else begin
        state_q <= S_FETCH;
        addr_q  <= flush_pc;
      end
    end else begin
      head_q  <= head_q + PTR_W'(pops);
      count_q <= count_d;
      if (push) begin
        tail_q     <= tail_q + PTR_W'(1);
        fetch_pc_q <= pc_inc;
      end
      case (state_q)
        S_FETCH: begin
          if (push && !has_room) begin
            state_q <= S_FULL;
            req_q   <= 1'b0;
          end else begin
            req_q  <= 1'b1;
            addr_q <= push ? pc_inc : fetch_pc_q;
          end
        end
        S_FULL: begin
          if (has_room) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        S_DISCARD: begin
          if (ack_v) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        default: begin
          state_q <= S_FETCH;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[tail_q] <= {imem_rdata, fetch_pc_q};
  end

  always_comb begin
    entry0         = mem_q[head_q];
    entry1         = mem_q[head_nx];
    instruction0   = (count_q >= CNT_W'(1)) ? entry0[63:32] : 32'h0;
    pc0            = (count_q >= CNT_W'(1)) ? entry0[31:0]  : 32'h0;
    instruction1   = (count_q >= CNT_W'(2)) ? entry1[63:32] : 32'h0;
    pc1            = (count_q >= CNT_W'(2)) ? entry1[31:0]  : 32'h0;
    nothing_filled = (count_q == '0);
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

endmodule

// File: tb/tb_dual_fetch_queue.sv
// tb/tb_dual_fetch_queue.sv - randomized scoreboard bench for dual_fetch_queue
// Driver randomizes memory/scheduler traffic; monitor checks against a queue model.
module tb_dual_fetch_queue;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        consume0 = 1'b0;
  logic        consume1 = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic [31:0] instruction0, instruction1, pc0, pc1;
  logic        nothing_filled;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] mq[$];
  logic [31:0] exp_pc    = RESET_PC;
  logic        disc      = 1'b0;
  logic [31:0] disc_addr = 32'h0;
  int          stall     = 0;

  dual_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .consume0(consume0), .consume1(consume1),
    .flush(flush), .flush_pc(flush_pc),
    .instruction0(instruction0), .instruction1(instruction1),
    .pc0(pc0), .pc1(pc1), .nothing_filled(nothing_filled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare current DUT view with the model, then advance the model
  // by the inputs that the next rising edge will see.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      exp_pc = RESET_PC;
      disc   = 1'b0;
      stall  = 0;
    end else begin
      logic [63:0] e0, e1;
      int          sz;
      logic        ack_eff;
      sz = mq.size();
      e0 = (sz >= 1) ? mq[0] : 64'h0;
      e1 = (sz >= 2) ? mq[1] : 64'h0;
      check("nothing_filled", {31'h0, nothing_filled}, {31'h0, sz == 0});
      check("instruction0", instruction0, e0[63:32]);
      check("pc0", pc0, e0[31:0]);
      check("instruction1", instruction1, e1[63:32]);
      check("pc1", pc1, e1[31:0]);
      if (sz == DEPTH) check("req_when_full", {31'h0, imem_req}, 32'h0);
      if (disc) begin
        check("discard_req", {31'h0, imem_req}, 32'h1);
        check("discard_addr", imem_addr, disc_addr);
      end else if (imem_req) begin
        check("fetch_addr", imem_addr, exp_pc);
      end
      if (!imem_req && !disc && sz < DEPTH) stall++;
      else stall = 0;
      check("req_liveness", {31'h0, stall <= 1}, 32'h1);

      ack_eff = imem_req && imem_ack;
      if (flush) begin
        mq.delete();
        exp_pc = flush_pc;
        if (imem_req && !ack_eff) begin
          if (!disc) disc_addr = imem_addr;
          disc = 1'b1;
        end else begin
          disc = 1'b0;
        end
      end else begin
        if (consume0 && sz >= 1) void'(mq.pop_front());
        if (consume0 && consume1 && sz >= 2) void'(mq.pop_front());
        if (ack_eff) begin
          if (disc) begin
            disc = 1'b0;
          end else begin
            mq.push_back({imem_rdata, exp_pc});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic cyc(input int ap, input int c0p, input int c1p, input int fp);
    logic [31:0] r;
    @(posedge clk);
    #1;
    imem_ack   = imem_req && (int'($urandom_range(99)) < ap);
    imem_rdata = $urandom;
    consume0   = int'($urandom_range(99)) < c0p;
    consume1   = int'($urandom_range(99)) < c1p;
    flush      = int'($urandom_range(99)) < fp;
    r = $urandom;
    if ($urandom_range(7) == 0) r = 32'hFFFF_FFF0;
    flush_pc = {r[31:2], 2'b00};
  endtask

  task automatic check_reset_outputs();
    check("rst_instruction0", instruction0, 32'h0);
    check("rst_instruction1", instruction1, 32'h0);
    check("rst_pc0", pc0, 32'h0);
    check("rst_pc1", pc1, 32'h0);
    check("rst_nothing_filled", {31'h0, nothing_filled}, 32'h1);
    check("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    int guard;
    #2;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fill to capacity, release one slot, refill, then drain in pairs.
    repeat (12) cyc(100, 0, 0, 0);
    cyc(0, 100, 0, 0);
    repeat (4) cyc(100, 0, 0, 0);
    cyc(0, 100, 0, 0);
    cyc(100, 0, 0, 0);
    cyc(100, 0, 0, 0);
    repeat (6) cyc(0, 100, 100, 0);

    // Mixed random traffic, including over-asking consumes and flushes.
    repeat (1500) cyc(70, 50, 50, 0);
    repeat (1000) cyc(60, 40, 60, 5);
    repeat (800)  cyc(20, 30, 50, 8);
    repeat (500)  cyc(90, 10, 10, 3);

    // Reset mid-fill with an outstanding request.
    cyc(0, 0, 0, 100);
    guard = 0;
    while (!(mq.size() >= 5 && imem_req) && guard < 60) begin
      cyc(100, 0, 0, 0);
      guard++;
    end
    check("fill5_timeout", {31'h0, guard < 60}, 32'h1);
    @(posedge clk);
    imem_ack = 1'b0; consume0 = 1'b0; consume1 = 1'b0; flush = 1'b0;
    #3 rst = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (600) cyc(70, 40, 40, 2);

    @(posedge clk);
    #1;
    imem_ack = 1'b0; consume0 = 1'b0; consume1 = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_fetch_queue.md
Name: dual_fetch_queue

Overview:
Instruction fetch queue that sits directly upstream of the dual-issue scheduler/cache stage. It fetches 32-bit words from instruction memory through a single-outstanding req/ack handshake and buffers them in a circular FIFO. Each cycle it presents the two oldest words as instruction0/instruction1. The scheduler retires zero, one or two of them per cycle, and a flush redirects fetch for jumps and taken branches.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 4
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
imem_req  output  1  fetch request, registered
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  memory accepted request; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
consume0  input  1  scheduler retires slot 0 this cycle
consume1  input  1  scheduler retires slot 1 this cycle; honoured only with consume0
flush  input  1  discard queue, redirect fetch
flush_pc  input  32  redirect target, word aligned
instruction0  output  32  oldest entry, or 32'h0 when count<1
instruction1  output  32  second-oldest entry, or 32'h0 when count<2
pc0  output  32  address of instruction0 (0 when invalid)
pc1  output  32  address of instruction1 (0 when invalid)
nothing_filled  output  1  queue empty (count==0)

Behaviour:
- Storage: DEPTH x 64 bits (word + pc); head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (rst=0, async): head=tail=count=0, fetch_pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC. Outputs are 0 and nothing_filled=1. imem_req first rises on the first clock edge after rst deasserts.
- FSM states:
  - FETCH: imem_req=1, imem_addr=fetch_pc.
  - FULL: imem_req=0.
  - DISCARD: imem_req=1 with the old address; returned data is dropped.
- FETCH transitions:
  - On imem_ack, write {imem_rdata, fetch_pc} at tail, tail+1, fetch_pc+4.
  - Stay in FETCH with back-to-back requests while next_count<DEPTH; otherwise go to FULL.
- FULL -> FETCH: when next_count<DEPTH.
- Pops:
  - consume0 && count>=1 pops 1.
  - consume0 && consume1 && count>=2 pops 2.
  - consume1 without consume0 pops nothing.
  - Consume requests beyond count are ignored.
- Count update: next_count = count + push - pops. Simultaneous push and pop at count==DEPTH is impossible, because no request is outstanding in FULL.
- Latency: data is visible on instruction0 on the cycle after imem_ack (empty queue). A pop removes the entry on the next edge.
- Output ordering: instruction0/1 and pc0/pc1 are combinational from head and head+1 (wrapping), gated by count.
- Flush, checked before pop/push:
  - head=tail=count=0 and fetch_pc=flush_pc; pops and pushes that cycle are ignored.
  - If the current state is FETCH with imem_ack=0, the request is outstanding: go to DISCARD, hold imem_req=1 and the old address until ack, drop that data, then go to FETCH with imem_addr=flush_pc on the next cycle.
  - If imem_ack=1 in the flush cycle, drop the data and go to FETCH at flush_pc.
  - From FULL, go to FETCH at flush_pc.
- Flush during DISCARD: update fetch_pc to the newer flush_pc and stay in DISCARD.
- Reset mid-operation: async clear to reset values, with no dependence on in-flight ack.
- fetch_pc wraps from 32'hFFFF_FFFC to 0.

Test Plan:
- Reset, then ack every cycle with rdata=0x00000013,0x00100093,... -> imem_addr 0,4,8,..; instruction0=0x13, pc0=0 one cycle after the first ack; nothing_filled falls on the same cycle.
- DEPTH=8, no consumes, ack always -> imem_req drops the cycle after the 8th ack; count=8; after one consume0, imem_req returns to 1 with addr 0x20.
- Queue holds 3 entries; consume0=consume1=1 -> next cycle instruction0 = the old third word and instruction1=0. Repeat with 1 entry and both consumes -> only one pop, nothing_filled=1.
- Pointer wrap: fill 8, pop 2, fetch 2, pop 8 in pairs -> words emerge in fetch order with pcs 0x00..0x24 contiguous.
- flush_pc=0x100 while a request to 0x0C is pending (ack delayed 3 cycles) -> imem_addr holds 0x0C until ack; its data is not enqueued; next request is 0x100; instruction0 then shows the 0x100 word.
- rst pulled low mid-fill with 5 entries and an outstanding request -> all outputs 0 immediately and nothing_filled=1; after release the fetch restarts at RESET_PC.
